// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-ported register file.
// The REGFILE_BYPASS_EN macro, used by regfile_rd_port, selects same-cycle write-to-read bypass.
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int REG_DEPTH     = 2 ** RF_ADDR_WIDTH;
    localparam int ZERO_REG      = 0;

    function automatic int reg_depth(input int aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero-register masking, optional same-cycle write bypass, busy lookup.
// Bypass is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WR     = 1,
    parameter int DEPTH      = REG_DEPTH
) (
    input  logic                           run,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    input  logic [DATA_WIDTH-1:0]          rf_word,
    input  logic [DEPTH-1:0]               busy,
    input  logic [NUM_WR-1:0]              wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           rbusy
);

    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_data_s;

`ifdef REGFILE_BYPASS_EN
    // Find the highest-index enabled write port targeting this read address
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            logic match_s;
            match_s    = wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_REG))
                         && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr);
            hit_s      = hit_s | match_s;
            hit_data_s = match_s ? wdata[j*DATA_WIDTH +: DATA_WIDTH] : hit_data_s;
        end
    end
`else
    logic unused_bypass_s;
    assign unused_bypass_s = ^{wen, waddr, wdata, set_en, set_addr};
    assign hit_s           = 1'b0;
    assign hit_data_s      = '0;
`endif

    // Select read data and busy: masked during the sweep and for r0, bypassed on a write hit
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!run || (raddr == ADDR_WIDTH'(ZERO_REG))) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (hit_s) begin
            rdata = hit_data_s;
            rbusy = set_en && (set_addr == raddr);
        end else begin
            rdata = rf_word;
            rbusy = busy[raddr];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: array, post-reset clear sweep, fixed-priority writes, busy scoreboard.
// Optional same-cycle bypass in the read ports when REGFILE_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready,
    input  logic [NUM_WR-1:0]              wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr
);

    localparam int DEPTH = reg_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] rf_r [DEPTH];
    rf_state_e             state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  ready_r;
    logic [DEPTH-1:0]      busy_r;
    logic [DEPTH-1:0]      busy_nxt_s;
    logic                  run_s;

    assign run_s = (state_r == ST_RUN);
    assign ready = ready_r;

    // Scoreboard next state: writebacks clear, issue sets afterwards so the newer producer wins
    always_comb begin
        busy_nxt_s = busy_r;
        for (int j = 0; j < NUM_WR; j++) begin
            busy_nxt_s[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] =
                busy_nxt_s[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] & ~wen[j];
        end
        busy_nxt_s[set_addr] = busy_nxt_s[set_addr] | set_en;
        busy_nxt_s[ZERO_REG] = 1'b0;
    end

    // Sweep FSM, array writes (later ports overwrite earlier ones) and scoreboard register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= ADDR_WIDTH'(1);
            ready_r <= 1'b0;
            busy_r  <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rf_r[cnt_r] <= '0;
                    cnt_r       <= cnt_r + ADDR_WIDTH'(1);
                    busy_r      <= '0;
                    if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_REG))) begin
                            rf_r[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    busy_r <= busy_nxt_s;
                end
                default: begin
                    state_r <= ST_INIT;
                    cnt_r   <= ADDR_WIDTH'(1);
                    ready_r <= 1'b0;
                    busy_r  <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_WIDTH-1:0] rf_word_s;
        assign rf_word_s = rf_r[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];

        regfile_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WR     (NUM_WR),
            .DEPTH      (DEPTH)
        ) u_rd_port (
            .run      (run_s),
            .raddr    (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .rf_word  (rf_word_s),
            .busy     (busy_r),
            .wen      (wen),
            .waddr    (waddr),
            .wdata    (wdata),
            .set_en   (set_en),
            .set_addr (set_addr),
            .rdata    (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy    (rbusy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset/sweep sequences, random traffic
// against a behavioural model. Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DEP = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              ready;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] waddr;
    logic [NWR*DW-1:0] wdata;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              set_en;
    logic [AW-1:0]     set_addr;

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .set_en(set_en), .set_addr(set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural register contents, busy bits and sweep progress
    logic [DW-1:0] m_rf   [DEP];
    bit            m_busy [DEP];
    bit            m_ready;
    int            m_edges;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        se;
        logic [4:0]  sa;
        logic [63:0] er0;
        logic [63:0] er1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t tbl [20];
    vec_t cur;
    bit   row_active = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_rd(input int p);
        int            a = int'(raddr[p*AW +: AW]);
        logic [DW-1:0] v;
        if (!m_ready || a == 0) return 64'd0;
        v = m_rf[a];
        if (BYP) begin
            for (int j = 0; j < NWR; j++)
                if (wen[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*DW +: DW];
        end
        return v;
    endfunction

    function automatic logic exp_bz(input int p);
        int a   = int'(raddr[p*AW +: AW]);
        bit hit = 1'b0;
        if (!m_ready || a == 0) return 1'b0;
        if (BYP) begin
            for (int j = 0; j < NWR; j++)
                if (wen[j] && int'(waddr[j*AW +: AW]) == a) hit = 1'b1;
        end
        if (hit) return set_en && (int'(set_addr) == a);
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int r = 0; r < DEP; r++) begin
                m_rf[r]   = '0;
                m_busy[r] = 1'b0;
            end
            m_ready = 1'b0;
            m_edges = 0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == DEP - 1) m_ready = 1'b1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                int a = int'(waddr[j*AW +: AW]);
                if (wen[j] && a != 0) begin
                    m_rf[a]   = wdata[j*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (set_en && set_addr != 5'd0) m_busy[int'(set_addr)] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("ready", 64'(ready), 64'(m_ready));
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], exp_rd(p));
            chk($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(exp_bz(p)));
        end
        if (row_active) begin
            chk("row rdata0", rdata[63:0], cur.er0);
            chk("row rdata1", rdata[127:64], cur.er1);
            chk("row rbusy0", 64'(rbusy[0]), 64'(cur.eb0));
            chk("row rbusy1", 64'(rbusy[1]), 64'(cur.eb1));
        end
    endtask

    // One clock: inputs already driven; check before the edge, advance the model at the edge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; raddr = '0; set_en = 1'b0; set_addr = '0;
    endtask

    task automatic rand_inputs();
        wen      = 2'($urandom);
        waddr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
        wdata    = {$urandom, $urandom, $urandom, $urandom};
        raddr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
        set_en   = 1'($urandom);
        set_addr = 5'($urandom_range(0, 15));
    endtask

    task automatic run_sweep(input string tag);
        for (int e = 1; e <= DEP - 1; e++) begin
            rand_inputs();
            cycle();
            chk($sformatf("%s ready after edge %0d", tag, e), 64'(ready), 64'(e == DEP - 1));
        end
    endtask

    function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [63:0] d0,
                                input logic [4:0] a1, input logic [63:0] d1,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic se, input logic [4:0] sa,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic b0, input logic b1);
        vec_t v;
        v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1; v.ra0 = r0; v.ra1 = r1;
        v.se = se; v.sa = sa; v.er0 = e0; v.er1 = e1; v.eb0 = b0; v.eb1 = b1;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(2'b01, 5'd5, 64'hDEAD_BEEF, 5'd0, 64'd0, 5'd5, 5'd0, 1'b0, 5'd0,
                     BYP ? 64'hDEAD_BEEF : 64'd0, 64'd0, 1'b0, 1'b0);
        tbl[1]  = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd5, 5'd5, 1'b0, 5'd0,
                     64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b0);
        tbl[2]  = mk(2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'd0, 5'd0, 5'd5, 1'b0, 5'd0,
                     64'd0, 64'hDEAD_BEEF, 1'b0, 1'b0);
        tbl[3]  = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0,
                     64'd0, 64'd0, 1'b0, 1'b0);
        tbl[4]  = mk(2'b11, 5'd7, 64'h1, 5'd7, 64'h2, 5'd7, 5'd5, 1'b0, 5'd0,
                     BYP ? 64'h2 : 64'd0, 64'hDEAD_BEEF, 1'b0, 1'b0);
        tbl[5]  = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd7, 5'd7, 1'b0, 5'd0,
                     64'h2, 64'h2, 1'b0, 1'b0);
        tbl[6]  = mk(2'b01, 5'd3, 64'h11, 5'd0, 64'd0, 5'd3, 5'd7, 1'b0, 5'd0,
                     BYP ? 64'h11 : 64'd0, 64'h2, 1'b0, 1'b0);
        tbl[7]  = mk(2'b01, 5'd3, 64'h55, 5'd0, 64'd0, 5'd3, 5'd3, 1'b0, 5'd0,
                     BYP ? 64'h55 : 64'h11, BYP ? 64'h55 : 64'h11, 1'b0, 1'b0);
        tbl[8]  = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd3, 5'd7, 1'b0, 5'd0,
                     64'h55, 64'h2, 1'b0, 1'b0);
        tbl[9]  = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9, 5'd3, 1'b1, 5'd9,
                     64'd0, 64'h55, 1'b0, 1'b0);
        tbl[10] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9, 5'd9, 1'b0, 5'd0,
                     64'd0, 64'd0, 1'b1, 1'b1);
        tbl[11] = mk(2'b01, 5'd9, 64'hAB, 5'd0, 64'd0, 5'd9, 5'd7, 1'b0, 5'd0,
                     BYP ? 64'hAB : 64'd0, 64'h2, BYP ? 1'b0 : 1'b1, 1'b0);
        tbl[12] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9, 5'd9, 1'b0, 5'd0,
                     64'hAB, 64'hAB, 1'b0, 1'b0);
        tbl[13] = mk(2'b10, 5'd0, 64'd0, 5'd9, 64'hCD, 5'd9, 5'd9, 1'b1, 5'd9,
                     BYP ? 64'hCD : 64'hAB, BYP ? 64'hCD : 64'hAB, BYP, BYP);
        tbl[14] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9, 5'd9, 1'b0, 5'd0,
                     64'hCD, 64'hCD, 1'b1, 1'b1);
        tbl[15] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd9, 1'b1, 5'd0,
                     64'd0, 64'hCD, 1'b0, 1'b1);
        tbl[16] = mk(2'b11, 5'd12, 64'h3, 5'd13, 64'h4, 5'd0, 5'd12, 1'b0, 5'd0,
                     64'd0, BYP ? 64'h3 : 64'd0, 1'b0, 1'b0);
        tbl[17] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd12, 5'd13, 1'b0, 5'd0,
                     64'h3, 64'h4, 1'b0, 1'b0);
        tbl[18] = mk(2'b11, 5'd13, 64'h5, 5'd12, 64'h6, 5'd12, 5'd13, 1'b1, 5'd12,
                     BYP ? 64'h6 : 64'h3, BYP ? 64'h5 : 64'h4, BYP, 1'b0);
        tbl[19] = mk(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd12, 5'd13, 1'b0, 5'd0,
                     64'h6, 64'h5, 1'b1, 1'b0);

        // Initial reset, partial sweep, reset during INIT, then full sweep
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        model_edge();
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        run_sweep("init");

        // Directed vector table
        row_active = 1'b1;
        for (int r = 0; r < 20; r++) begin
            cur      = tbl[r];
            wen      = cur.wen;
            waddr    = {cur.wa1, cur.wa0};
            wdata    = {cur.wd1, cur.wd0};
            raddr    = {cur.ra1, cur.ra0};
            set_en   = cur.se;
            set_addr = cur.sa;
            cycle();
        end
        row_active = 1'b0;

        // Reset mid-RUN: same-cycle write/set dropped, sweep re-run, INIT writes discarded
        idle();
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {64'd0, 64'h77};
        cycle();
        idle();
        raddr = {5'd0, 5'd4};
        cycle();
        chk("r4 before reset", rdata[63:0], 64'h77);
        rst_n = 1'b0;
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {64'd0, 64'h99}; set_en = 1'b1; set_addr = 5'd4;
        cycle();
        chk("ready drops after reset", 64'(ready), 64'd0);
        rst_n = 1'b1;
        run_sweep("rerun");
        idle();
        raddr = {5'd0, 5'd4};
        #1;
        chk("r4 after sweep", rdata[63:0], 64'd0);
        chk("r4 busy after sweep", 64'(rbusy[0]), 64'd0);
        cycle();

        // Random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-ported, parametrised general-purpose register file for the next-generation NPC core, replacing the single-write/dual-read register file. Provides NUM_RD combinational read ports, NUM_WR write ports with fixed priority, hardwired zero register, a per-register busy scoreboard for the issue stage, and a sequential post-reset clear sweep with a `ready` indication. Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register width
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ready  out  1  register file initialised and accepting writes
- wen  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_WIDTH  write addresses, port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_WR*DATA_WIDTH  write data, same packing
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses
- rdata  out  NUM_RD*DATA_WIDTH  read data
- rbusy  out  NUM_RD  busy bit of the register addressed by each read port
- set_en  in  1  mark register busy (instruction issued with destination)
- set_addr  in  ADDR_WIDTH  register to mark busy

## Operation
- State machine: INIT, RUN. Reset forces INIT, sweep counter `cnt` = 1, `ready` = 0, all busy bits = 0.
- INIT: each cycle rf[cnt] <= 0, cnt <= cnt+1; on the cycle cnt == 2**ADDR_WIDTH-1 the last clear is written and state <= RUN. wen and set_en ignored in INIT; rdata = 0, rbusy = 0 on all ports.
- RUN: for each j, wen[j] && waddr[j] != 0 writes wdata[j] to rf[waddr[j]] and clears busy[waddr[j]].
- Write conflict: two ports same non-zero address same cycle -> higher port index wins.
- set_en && set_addr != 0 sets busy[set_addr]; set and clear of same address in same cycle -> set wins (newer producer).
- Register 0: never written, never busy, always reads 0.
- Read: rdata[i] = 0 if raddr[i] == 0, else rf[raddr[i]] (plus bypass, see Configuration). rbusy[i] = busy[raddr[i]].

## Timing
- Reads and rbusy combinational from current-cycle addresses and state (zero latency).
- Writes and busy updates visible to reads the cycle after the edge that commits them.
- Reset release: ready rises after the (2**ADDR_WIDTH-1)-th rising edge with rst_n high; 31 edges for ADDR_WIDTH=5.
- Reset asserted during INIT restarts the sweep from cnt = 1.
- Reset asserted during RUN: same-cycle writes/sets dropped, busy cleared, full sweep re-run.
- Output reset values: ready = 0, rdata = 0, rbusy = 0.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, a read port whose raddr matches a same-cycle enabled write with non-zero address returns that wdata (highest-index matching write port), and rbusy for that port reads 0 unless set_en targets the same address.
- Not defined: reads return the pre-edge array contents; same-cycle writes are seen next cycle only. rbusy reflects registered busy only.

## Structure
- Shared package `regfile_pkg`: state enum (INIT, RUN), constant REG_DEPTH = 2**ADDR_WIDTH, zero-register index constant.
- One sub-module: `regfile_rd_port` (one read port: zero check, bypass mux, busy lookup), instantiated NUM_RD times in a generate loop. Array, sweep FSM, write priority and scoreboard live in the top.

## Test plan
- Reset release, ADDR_WIDTH=5: ready = 0 for 30 edges, 1 after 31st; all reads 0; busy all 0.
- Write 0xDEAD_BEEF to r5 via port 0, read r5 next cycle on both ports -> 0xDEAD_BEEF; write to r0 -> r0 reads 0.
- NUM_WR=2: port 0 writes 0x1 and port 1 writes 0x2 to r7 same cycle -> r7 reads 0x2.
- Same-cycle write 0x55 to r3 and read r3 (old 0x11): with REGFILE_BYPASS_EN -> 0x55; without -> 0x11, then 0x55 next cycle.
- set_en r9 -> rbusy=1 next cycle; write r9 -> rbusy=0 next cycle; set and write r9 same cycle -> rbusy stays 1.
- Assert rst_n low mid-RUN after writing r4 = 0x77 -> ready drops next cycle, r4 reads 0 after sweep, writes during INIT discarded.
